// File: rtl/sad_best_match.sv
// Minimum-SAD search tracker: consumes one SAD per candidate over valid/ready
// and reports the lowest SAD and its candidate index with a one-cycle done pulse.
module sad_best_match #(
  parameter int SAD_W = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_cand,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             sad_valid,
  output logic             sad_ready,
  output logic [IDX_W-1:0] cand_idx,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             best_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [SAD_W-1:0] SAD_ONES = '1;

  state_t           state_reg;
  logic [IDX_W-1:0] cnt_max_reg;
  logic [IDX_W-1:0] cand_idx_reg;
  logic [IDX_W-1:0] best_idx_reg;
  logic [SAD_W-1:0] best_sad_reg;
  logic             best_valid_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;

  // Handshake flags are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_max_reg    <= '0;
      cand_idx_reg   <= '0;
      best_idx_reg   <= '0;
      best_sad_reg   <= SAD_ONES;
      best_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_max_reg    <= num_cand;
            cand_idx_reg   <= '0;
            best_idx_reg   <= '0;
            best_sad_reg   <= SAD_ONES;
            best_valid_reg <= 1'b0;
            busy_reg       <= 1'b1;
            if (num_cand == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= COLLECT;
              ready_reg <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (sad_valid) begin
            // Strict compare keeps the earliest candidate on ties.
            if (!best_valid_reg || (sad_in < best_sad_reg)) begin
              best_sad_reg <= sad_in;
              best_idx_reg <= cand_idx_reg;
            end
            best_valid_reg <= 1'b1;
            if (cand_idx_reg == (cnt_max_reg - IDX_ONE)) begin
              state_reg <= DONE;
              ready_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              cand_idx_reg <= cand_idx_reg + IDX_ONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign sad_ready  = ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cand_idx   = cand_idx_reg;
  assign best_sad   = best_sad_reg;
  assign best_idx   = best_idx_reg;
  assign best_valid = best_valid_reg;

endmodule
